sn54ls161: RTL

- Synchronous presettable binary counter modelled on the SN54LS161: 4-bit default, asynchronous clear, synchronous load, dual count enables and a ripple-carry output.
- Sits directly upstream of the SN54LS32 quad-OR stage. Its Q outputs and RCO drive the OR gate inputs, for example OR-combining count bits or cascade carries.
- Supplies the stepped stimulus pattern that the OR stage consumes.

---
 rtl/sn54ls_pkg.sv | 26 ++
 rtl/sn54ls_tc_detect.sv | 30 +++
 rtl/sn54ls161.sv | 84 ++++++++
 3 files changed

// File: rtl/sn54ls_pkg.sv
// Shared definitions for the SN54LS-series counter models (161/163/169).
// Contents:
//   SN54LS_CNT_WIDTH_DEF - default counter width
//   SN54LS_CNT_MOD_DEF   - default counter modulus
//   cnt_dir_e            - count direction
//   sn54ls_is_terminal   - terminal-count predicate (up: q==modulus-1, down: q==0)
package sn54ls_pkg;

  localparam int unsigned SN54LS_CNT_WIDTH_DEF = 4;
  localparam int unsigned SN54LS_CNT_MOD_DEF   = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  // q is zero-extended by the caller to 16 bits, the widest legal counter.
  function automatic logic sn54ls_is_terminal(input logic [15:0] q,
                                              input logic        up,
                                              input int unsigned modulus);
    logic [15:0] last;
    last = 16'(modulus - 1);
    return up ? (q == last) : (q == '0);
  endfunction

endpackage

// File: rtl/sn54ls_tc_detect.sv
// Combinational terminal-count and ripple-carry detection for SN54LS counters.
// Ports:
//   q   - current counter state
//   ent - count enable T; gates rco only
//   dir - count direction (DIR_UP / DIR_DOWN)
//   tc  - terminal count reached, ungated
//   rco - ripple carry out = ent & tc
module sn54ls_tc_detect
  import sn54ls_pkg::*;
#(
  parameter int unsigned WIDTH   = SN54LS_CNT_WIDTH_DEF,
  parameter int unsigned MODULUS = SN54LS_CNT_MOD_DEF
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ent,
  input  cnt_dir_e         dir,
  output logic             tc,
  output logic             rco
);

  logic [15:0] q_ext;

  always_comb begin
    q_ext            = '0;
    q_ext[WIDTH-1:0] = q;
    tc               = sn54ls_is_terminal(q_ext, dir == DIR_UP, MODULUS);
    rco              = ent & tc;
  end

endmodule

// File: rtl/sn54ls161.sv
// Synchronous presettable binary counter modelled on the SN54LS161.
// Asynchronous active-low clear, synchronous active-low load (priority over
// counting), dual count enables, combinational ripple-carry output.
// Optional build macro SN54LS161_UPDOWN_EN adds i_U_D (1 = up, 0 = down),
// SN54LS169 style; without it the counter is up-only.
// Ports:
//   i_CLK    - clock, rising-edge active
//   i_CLR_N  - asynchronous active-low clear
//   i_LOAD_N - synchronous active-low parallel load
//   i_ENP    - count enable P (does not gate RCO)
//   i_ENT    - count enable T (gates RCO)
//   i_U_D    - count direction (only with SN54LS161_UPDOWN_EN)
//   i_D      - parallel load data, i_D[0] = pin A
//   o_Q      - counter state, o_Q[0] = QA
//   o_RCO    - ripple carry out, combinational
module sn54ls161
  import sn54ls_pkg::*;
#(
  parameter int unsigned WIDTH   = SN54LS_CNT_WIDTH_DEF,
  parameter int unsigned MODULUS = SN54LS_CNT_MOD_DEF
) (
  input  logic             i_CLK,
  input  logic             i_CLR_N,
  input  logic             i_LOAD_N,
  input  logic             i_ENP,
  input  logic             i_ENT,
`ifdef SN54LS161_UPDOWN_EN
  input  logic             i_U_D,
`endif
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_RCO
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             tc;
  cnt_dir_e         dir;

`ifdef SN54LS161_UPDOWN_EN
  assign dir = i_U_D ? DIR_UP : DIR_DOWN;
`else
  assign dir = DIR_UP;
`endif

  sn54ls_tc_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .q   (q_reg),
    .ent (i_ENT),
    .dir (dir),
    .tc  (tc),
    .rco (o_RCO)
  );

  // tc covers the terminal value; q_reg > LAST catches out-of-range loads,
  // which both directions fold back into the legal range on the next count.
  always_comb begin
    q_next = q_reg;
    if (!i_LOAD_N) begin
      q_next = i_D;
    end else if (i_ENP && i_ENT) begin
      if (dir == DIR_UP) begin
        q_next = (tc || (q_reg > LAST)) ? '0 : q_reg + 1'b1;
      end else begin
        q_next = (tc || (q_reg > LAST)) ? LAST : q_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_CLR_N) begin
    if (!i_CLR_N) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign o_Q = q_reg;

endmodule
